// File: rtl/lcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : lcd_pkg                                                |
// | Description : Shared types and constants for the HD44780-class LCD   |
// |               bus sequencer.                                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package lcd_pkg;

  // Width of the LCD data bus and of request/response data.
  localparam int LCD_DATA_W = 8;

  // Register select encodings on lcd_rs.
  localparam logic LCD_RS_INSTR = 1'b0;
  localparam logic LCD_RS_DATA  = 1'b1;

  // Position of the busy flag in a status (rs=0, rw=1) read.
  localparam int LCD_BF_BIT = 7;

  // Sequencer phases. The POLL_* states repeat the bus cycle shape of the
  // main access but always perform a status read.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SETUP      = 3'd1,
    E_HIGH     = 3'd2,
    HOLD       = 3'd3,
    POLL_SETUP = 3'd4,
    POLL_E     = 3'd5,
    POLL_HOLD  = 3'd6
  } state_t;

  // Largest of three phase lengths; sizes the shared phase counter.
  function automatic int lcd_max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_bus_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface   : lcd_bus_sequencer_if                                   |
// | Description : Host-side request/response handshake of the LCD bus    |
// |               sequencer.                                             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface lcd_bus_sequencer_if;
  import lcd_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_rs;
  logic                  req_rw;
  logic [LCD_DATA_W-1:0] req_data;
  logic                  rsp_valid;
  logic [LCD_DATA_W-1:0] rsp_data;
  logic                  busy;
  logic                  err_timeout;

  // Host side: issues requests, observes status and read data.
  modport master (
    output req_valid, req_rs, req_rw, req_data,
    input  req_ready, rsp_valid, rsp_data, busy, err_timeout
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_rs, req_rw, req_data,
    output req_ready, rsp_valid, rsp_data, busy, err_timeout
  );

endinterface
`default_nettype wire

// File: rtl/lcd_phase_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lcd_phase_timer                                        |
// | Description : Loadable down-counter with a done flag. Loaded with    |
// |               N-1 on entry to a phase, done marks the phase's last   |
// |               cycle. Holds at zero instead of wrapping.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module lcd_phase_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Reload on phase entry, otherwise count down and stop at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule
`default_nettype wire

// File: rtl/lcd_bus_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lcd_bus_sequencer                                      |
// | Description : Turns single-beat instruction/data read and write      |
// |               requests into timed HD44780 bus cycles (RS/RW setup,   |
// |               E pulse, hold), optionally polling the busy flag after |
// |               each write until it clears or a poll limit is hit.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module lcd_bus_sequencer
  import lcd_pkg::*;
#(
  parameter int T_AS    = 2,
  parameter int T_PW    = 12,
  parameter int T_H     = 2,
  parameter int BF_POLL = 1,
  parameter int BF_MAX  = 4095
) (
  input  logic                  clk,
  input  logic                  reset_n,
  lcd_bus_sequencer_if.slave    host,
  inout  wire  [LCD_DATA_W-1:0] lcd_data,
  output logic                  lcd_rs,
  output logic                  lcd_rw,
  output logic                  lcd_e
);

  localparam int TW = $clog2(lcd_max3(T_AS, T_PW, T_H)) + 1;
  localparam int PW = $clog2(BF_MAX + 1);

  localparam logic [TW-1:0] AS_LOAD  = TW'(T_AS - 1);
  localparam logic [TW-1:0] PW_LOAD  = TW'(T_PW - 1);
  localparam logic [TW-1:0] H_LOAD   = TW'(T_H - 1);
  localparam logic [PW-1:0] POLL_LIM = PW'(BF_MAX);

  state_t                state;
  state_t                next_state;
  logic                  accept;
  logic                  timer_load;
  logic [TW-1:0]         timer_val;
  logic                  phase_done;
  logic                  poll_clear;
  logic                  poll_inc;
  logic                  rsp_fire;
  logic                  timeout_fire;
  logic                  drive_en;
  logic [LCD_DATA_W-1:0] data_q;
  logic [LCD_DATA_W-1:0] rd_q;
  logic                  bf_q;
  logic [PW-1:0]         poll_cnt;
  logic                  ready_q;
  logic                  rsp_valid_q;
  logic [LCD_DATA_W-1:0] rsp_data_q;
  logic                  err_q;

  assign accept = host.req_valid && ready_q;

  lcd_phase_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (phase_done)
  );

  // State register; reset abandons any partial access immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode, phase timer reloads and one-shot event strobes.
  always_comb begin
    next_state   = state;
    timer_load   = 1'b0;
    timer_val    = '0;
    poll_clear   = 1'b0;
    poll_inc     = 1'b0;
    rsp_fire     = 1'b0;
    timeout_fire = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = SETUP;
          timer_load = 1'b1;
          timer_val  = AS_LOAD;
        end
      end
      SETUP: begin
        if (phase_done) begin
          next_state = E_HIGH;
          timer_load = 1'b1;
          timer_val  = PW_LOAD;
        end
      end
      E_HIGH: begin
        if (phase_done) begin
          next_state = HOLD;
          timer_load = 1'b1;
          timer_val  = H_LOAD;
        end
      end
      HOLD: begin
        if (phase_done) begin
          if (lcd_rw) begin
            next_state = IDLE;
            rsp_fire   = 1'b1;
          end else if (BF_POLL != 0) begin
            next_state = POLL_SETUP;
            timer_load = 1'b1;
            timer_val  = AS_LOAD;
            poll_clear = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      POLL_SETUP: begin
        if (phase_done) begin
          next_state = POLL_E;
          timer_load = 1'b1;
          timer_val  = PW_LOAD;
        end
      end
      POLL_E: begin
        if (phase_done) begin
          next_state = POLL_HOLD;
          timer_load = 1'b1;
          timer_val  = H_LOAD;
        end
      end
      POLL_HOLD: begin
        if (phase_done) begin
          if (!bf_q) begin
            next_state = IDLE;
          end else if (poll_cnt < POLL_LIM) begin
            next_state = POLL_SETUP;
            timer_load = 1'b1;
            timer_val  = AS_LOAD;
            poll_inc   = 1'b1;
          end else begin
            next_state   = IDLE;
            timeout_fire = 1'b1;
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // LCD control pins and captured write data; RW parks high whenever idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lcd_rs <= LCD_RS_INSTR;
      lcd_rw <= 1'b1;
      lcd_e  <= 1'b0;
      data_q <= '0;
    end else begin
      lcd_e <= (next_state == E_HIGH) || (next_state == POLL_E);
      if (accept) begin
        lcd_rs <= host.req_rs;
        lcd_rw <= host.req_rw;
        data_q <= host.req_data;
      end else if (poll_clear || poll_inc) begin
        lcd_rs <= LCD_RS_INSTR;
        lcd_rw <= 1'b1;
      end else if ((next_state == IDLE) && (state != IDLE)) begin
        lcd_rw <= 1'b1;
      end
    end
  end

  // Bus sampling on the last E cycle and the busy-flag poll counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q     <= '0;
      bf_q     <= 1'b0;
      poll_cnt <= '0;
    end else begin
      if ((state == E_HIGH) && phase_done && lcd_rw) begin
        rd_q <= lcd_data;
      end
      if ((state == POLL_E) && phase_done) begin
        bf_q <= lcd_data[LCD_BF_BIT];
      end
      if (poll_clear) begin
        poll_cnt <= '0;
      end else if (poll_inc) begin
        poll_cnt <= poll_cnt + PW'(1);
      end
    end
  end

  // Host-side handshake and response registers. Ready stays low for the
  // first IDLE cycle so a request is never taken on the return edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      ready_q     <= (state == IDLE) && !accept;
      rsp_valid_q <= rsp_fire;
      err_q       <= timeout_fire;
      if (rsp_fire) begin
        rsp_data_q <= rd_q;
      end
    end
  end

  // Data bus is driven only across a write access; polls and reads float it.
  assign drive_en = !lcd_rw && ((state == SETUP) || (state == E_HIGH) || (state == HOLD));
  assign lcd_data = drive_en ? data_q : {LCD_DATA_W{1'bz}};

  assign host.req_ready   = ready_q;
  assign host.rsp_valid   = rsp_valid_q;
  assign host.rsp_data    = rsp_data_q;
  assign host.busy        = (state != IDLE);
  assign host.err_timeout = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_lcd_bus_sequencer                                   |
// | Description : Scoreboard bench for lcd_bus_sequencer. Two instances: |
// |               index 0 without busy polling, index 1 with polling and |
// |               a poll limit of 5. A small LCD model answers reads.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_lcd_bus_sequencer;
  import lcd_pkg::*;

  localparam int T_AS  = 2;
  localparam int T_PW  = 4;
  localparam int T_H   = 2;
  localparam int PHASE = T_AS + T_PW + T_H;

  typedef struct {
    int         busy_cyc;
    int         e_off;
    int         e_width;
    int         strobes;
    int         bus_hits;
    logic [7:0] match_val;
    int         rsp_n;
    logic [7:0] rsp_data;
    int         err_n;
    logic       rs;
    logic       rw;
  } exp_t;

  exp_t sb_q[$];

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sel = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic       req_rw = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic [7:0] read_val = 8'h5A;
  int         bf_busy = 0;
  logic       probe_en = 1'b0;
  logic [7:0] probe_val = 8'h3C;

  logic       ready_a[2], rspv_a[2], busy_a[2], err_a[2], e_a[2], rs_a[2], rw_a[2];
  logic [7:0] rspd_a[2], bus_a[2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Device under test instances, each with its own LCD bus and model.
  generate
    for (genvar g = 0; g < 2; g++) begin : g_dut
      lcd_bus_sequencer_if bus_if ();
      wire  [7:0] lcd_data;
      logic       lcd_rs, lcd_rw, lcd_e;
      logic       mine;
      logic       e_d = 1'b0;
      int         polls_seen = 0;

      assign mine             = (int'(sel) == g);
      assign bus_if.req_valid = req_valid && mine;
      assign bus_if.req_rs    = req_rs;
      assign bus_if.req_rw    = req_rw;
      assign bus_if.req_data  = req_data;

      // LCD model: answers reads while E is high; status reads report busy
      // for the first bf_busy polls of a transaction.
      assign lcd_data = probe_en ? probe_val :
                        (mine && lcd_e && lcd_rw) ?
                          (lcd_rs ? read_val : {(polls_seen < bf_busy), 7'h00}) :
                          8'hzz;

      always @(negedge clk) begin
        e_d <= lcd_e;
        if (!bus_if.busy) polls_seen <= 0;
        else if (e_d && !lcd_e && !lcd_rs && lcd_rw) polls_seen <= polls_seen + 1;
      end

      lcd_bus_sequencer #(
        .T_AS    (T_AS),
        .T_PW    (T_PW),
        .T_H     (T_H),
        .BF_POLL (g),
        .BF_MAX  ((g == 0) ? 4095 : 5)
      ) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .host     (bus_if),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_e    (lcd_e)
      );

      assign ready_a[g] = bus_if.req_ready;
      assign rspv_a[g]  = bus_if.rsp_valid;
      assign rspd_a[g]  = bus_if.rsp_data;
      assign busy_a[g]  = bus_if.busy;
      assign err_a[g]   = bus_if.err_timeout;
      assign e_a[g]     = lcd_e;
      assign rs_a[g]    = lcd_rs;
      assign rw_a[g]    = lcd_rw;
      assign bus_a[g]   = lcd_data;
    end
  endgenerate

  logic       m_ready, m_rspv, m_busy, m_err, m_e, m_rs, m_rw;
  logic [7:0] m_rspd, m_bus;
  assign m_ready = ready_a[sel];
  assign m_rspv  = rspv_a[sel];
  assign m_rspd  = rspd_a[sel];
  assign m_busy  = busy_a[sel];
  assign m_err   = err_a[sel];
  assign m_e     = e_a[sel];
  assign m_rs    = rs_a[sel];
  assign m_rw    = rw_a[sel];
  assign m_bus   = bus_a[sel];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic rs, input logic rw, input logic [7:0] match,
                                  input int polls, input int rsp_n, input logic [7:0] rsp_d,
                                  input int err_n);
    exp_t e;
    e.busy_cyc  = PHASE * (1 + polls);
    e.e_off     = T_AS;
    e.e_width   = T_PW;
    e.strobes   = 1 + polls;
    e.bus_hits  = rw ? T_PW : PHASE;
    e.match_val = match;
    e.rsp_n     = rsp_n;
    e.rsp_data  = rsp_d;
    e.err_n     = err_n;
    e.rs        = rs;
    e.rw        = rw;
    return e;
  endfunction

  // Transaction monitor: measures each busy window and compares it against
  // the oldest scoreboard entry on the first idle cycle.
  int   mon_busy, mon_eoff, mon_ew, mon_strobes, mon_hits, mon_rsp, mon_err, mon_bad;
  logic [7:0] mon_rspd;
  bit   in_txn = 0, seen_e, e_prev, pins_ok;
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_txn = 0;
      end else begin
        if (!in_txn && m_busy) begin
          in_txn = 1; mon_busy = 0; mon_eoff = -1; mon_ew = 0; mon_strobes = 0;
          mon_hits = 0; mon_rsp = 0; mon_err = 0; mon_bad = 0; mon_rspd = 8'h00;
          seen_e = 0; e_prev = 0;
        end
        if (in_txn && m_busy) begin
          mon_busy++;
          if (m_e && !seen_e) begin seen_e = 1; mon_eoff = mon_busy - 1; end
          if (m_e && mon_strobes == 0) mon_ew++;
          if (e_prev && !m_e) mon_strobes++;
          e_prev = m_e;
          if (sb_q.size() > 0) begin
            if (m_bus == sb_q[0].match_val) mon_hits++;
            if (mon_busy <= PHASE) pins_ok = (m_rs == sb_q[0].rs) && (m_rw == sb_q[0].rw);
            else                   pins_ok = (m_rs == 1'b0) && (m_rw == 1'b1);
            if (!pins_ok) mon_bad++;
          end
          if (m_rspv) mon_rsp++;
          if (m_err) mon_err++;
        end else if (in_txn) begin
          in_txn = 0;
          if (m_rspv) begin mon_rsp++; mon_rspd = m_rspd; end
          if (m_err) mon_err++;
          if (sb_q.size() == 0) begin
            check("sb_underflow", 32'(sb_q.size()), 32'd1);
          end else begin
            x = sb_q.pop_front();
            check("busy_cycles", mon_busy, x.busy_cyc);
            check("e_offset", mon_eoff, x.e_off);
            check("e_width", mon_ew, x.e_width);
            check("e_strobes", mon_strobes, x.strobes);
            check("bus_value_cycles", mon_hits, x.bus_hits);
            check("rs_rw_pins", mon_bad, 0);
            check("rsp_pulses", mon_rsp, x.rsp_n);
            if (x.rsp_n > 0) check("rsp_data", mon_rspd, x.rsp_data);
            check("err_pulses", mon_err, x.err_n);
            check("ready_first_idle", m_ready, 1'b0);
            check("rw_idle", m_rw, 1'b1);
          end
        end
      end
    end
  end

  // Issue one request from a negedge; checks accept-to-ready latency.
  task automatic do_req(input logic rs, input logic rw, input logic [7:0] d,
                        input exp_t x, input int exp_lat, input bit keep_valid);
    int n;
    sb_q.push_back(x);
    req_rs = rs; req_rw = rw; req_data = d; req_valid = 1'b1;
    n = 0;
    while (!m_ready && n < 200) begin @(negedge clk); n++; end
    if (!m_ready) begin
      check("accept_timeout", 32'(m_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (!keep_valid) req_valid = 1'b0;
    n = 0;
    while (!m_ready && n < 1000) begin @(negedge clk); n++; end
    check("ready_latency", n, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_ready", m_ready, 1'b0);
    check("rst_e", m_e, 1'b0);
    check("rst_rs", m_rs, 1'b0);
    check("rst_rw", m_rw, 1'b1);
    check("rst_busy", m_busy, 1'b0);
    check("rst_rsp_valid", m_rspv, 1'b0);
    check("rst_rsp_data", m_rspd, 8'h00);
    check("rst_err", m_err, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", m_ready, 1'b1);

    // Non-polling instance: data write, then two reads with different data.
    sel = 1'b0;
    do_req(1'b1, 1'b0, 8'h41, mk_exp(1'b1, 1'b0, 8'h41, 0, 0, 8'h00, 0), PHASE + 1, 1'b0);
    read_val = 8'h5A;
    do_req(1'b1, 1'b1, 8'hFF, mk_exp(1'b1, 1'b1, 8'h5A, 0, 1, 8'h5A, 0), PHASE + 1, 1'b0);
    read_val = 8'hA5;
    do_req(1'b1, 1'b1, 8'h00, mk_exp(1'b1, 1'b1, 8'hA5, 0, 1, 8'hA5, 0), PHASE + 1, 1'b0);

    // Polling instance: busy for three polls, then stuck busy, then a read.
    @(negedge clk); sel = 1'b1; @(negedge clk);
    bf_busy = 3;
    do_req(1'b0, 1'b0, 8'h01, mk_exp(1'b0, 1'b0, 8'h01, 4, 0, 8'h00, 0), PHASE * 5 + 1, 1'b0);
    bf_busy = 1000;
    do_req(1'b0, 1'b0, 8'h38, mk_exp(1'b0, 1'b0, 8'h38, 6, 0, 8'h00, 1), PHASE * 7 + 1, 1'b0);
    bf_busy = 0;
    read_val = 8'h5A;
    do_req(1'b1, 1'b1, 8'h00, mk_exp(1'b1, 1'b1, 8'h5A, 0, 1, 8'h5A, 0), PHASE + 1, 1'b0);

    // Back-to-back with req_valid held high across both requests.
    @(negedge clk); sel = 1'b0; @(negedge clk);
    do_req(1'b1, 1'b0, 8'h48, mk_exp(1'b1, 1'b0, 8'h48, 0, 0, 8'h00, 0), PHASE + 1, 1'b1);
    do_req(1'b1, 1'b0, 8'h69, mk_exp(1'b1, 1'b0, 8'h69, 0, 0, 8'h00, 0), PHASE + 1, 1'b0);

    // Reset asserted in the middle of the E pulse of a write.
    req_rs = 1'b1; req_rw = 1'b0; req_data = 8'h41; req_valid = 1'b1;
    n = 0;
    while (!m_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!m_e && n < 50) begin @(negedge clk); n++; end
    check("e_seen_before_rst", m_e, 1'b1);
    #2;
    reset_n = 1'b0;
    probe_en = 1'b1;
    #1;
    check("async_rst_e", m_e, 1'b0);
    check("async_rst_busy", m_busy, 1'b0);
    check("async_rst_bus_released", m_bus, 8'h3C);
    @(negedge clk);
    probe_en = 1'b0;
    reset_n = 1'b1;
    check("post_rst_rw", m_rw, 1'b1);
    @(negedge clk);
    do_req(1'b1, 1'b0, 8'h21, mk_exp(1'b1, 1'b0, 8'h21, 0, 0, 8'h00, 0), PHASE + 1, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
